adsr_envelope_multi: RTL and testbench

- Multi-channel, parametrised successor to the single-voice envelope generator.
- NUM_CH independent ADSR envelopes. Each channel has its own register-programmed rates and levels.
- Levels use rate accumulation (add/subtract per sample tick), so no divider is needed.
- Adds retrigger from the current level, saturation/clamping, and per-channel done pulses. Sits between the note-event decoder and the per-voice amplitude multiplier.

---
 rtl/eg_pkg.sv | 32 +++
 rtl/eg_channel.sv | 128 ++++++++++++
 rtl/adsr_envelope_multi.sv | 52 +++++
 tb/tb_adsr_envelope_multi.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/eg_pkg.sv
// ============================================================================
// Module  : eg_pkg
// Purpose : Shared state encoding, config select codes and reset defaults
//           for the multi-channel ADSR envelope generator.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package eg_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_ATTACK  = 5'b00010,
    ST_DECAY   = 5'b00100,
    ST_SUSTAIN = 5'b01000,
    ST_RELEASE = 5'b10000
  } eg_state_t;

  localparam logic [2:0] CFG_ATTACK  = 3'd0;
  localparam logic [2:0] CFG_DECAY   = 3'd1;
  localparam logic [2:0] CFG_SUSTAIN = 3'd2;
  localparam logic [2:0] CFG_RELEASE = 3'd3;
  localparam logic [2:0] CFG_PEAK    = 3'd4;

  // Rate defaults; sustain and peak defaults depend on LVL_W and are built in eg_channel.
  localparam int RST_ATTACK_RATE  = 1;
  localparam int RST_DECAY_RATE   = 1;
  localparam int RST_RELEASE_RATE = 1;

endpackage

`default_nettype wire

// File: rtl/eg_channel.sv
// ============================================================================
// Module  : eg_channel
// Purpose : One ADSR envelope: config registers, one-hot FSM, clamped level.
//           EG_EXP_RELEASE_EN selects the exponential-style release step.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module eg_channel
  import eg_pkg::*;
#(
  parameter int LVL_W = 18
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             tick,
  input  logic             note_on,
  input  logic             note_off,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_sel,
  input  logic [LVL_W-1:0] cfg_data,
  output logic [LVL_W-1:0] level,
  output logic             busy,
  output logic             done
);

  localparam logic [LVL_W-1:0] RST_SUSTAIN = {1'b1, {(LVL_W-1){1'b0}}};
  localparam logic [LVL_W-1:0] RST_PEAK    = {LVL_W{1'b1}};

  logic [LVL_W-1:0] attack_rate, decay_rate, sustain_level, release_rate, peak_level;
  eg_state_t        state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      attack_rate   <= LVL_W'(RST_ATTACK_RATE);
      decay_rate    <= LVL_W'(RST_DECAY_RATE);
      sustain_level <= RST_SUSTAIN;
      release_rate  <= LVL_W'(RST_RELEASE_RATE);
      peak_level    <= RST_PEAK;
    end else if (cfg_we) begin
      case (cfg_sel)
        CFG_ATTACK:  attack_rate   <= cfg_data;
        CFG_DECAY:   decay_rate    <= cfg_data;
        CFG_SUSTAIN: sustain_level <= cfg_data;
        CFG_RELEASE: release_rate  <= cfg_data;
        CFG_PEAK:    peak_level    <= cfg_data;
        default:     ;
      endcase
    end
  end

  // One extra bit so overflow and underflow are visible before clamping.
  logic [LVL_W:0]   att_sum, dec_diff, rel_diff;
  logic [LVL_W-1:0] rel_step;
  logic             att_hit, dec_hit, rel_hit;

  always_comb begin
`ifdef EG_EXP_RELEASE_EN
    rel_step = level >> release_rate[4:0];
    if (rel_step == '0) rel_step = LVL_W'(1);
`else
    rel_step = release_rate;
`endif
    att_sum  = {1'b0, level} + {1'b0, attack_rate};
    dec_diff = {1'b0, level} - {1'b0, decay_rate};
    rel_diff = {1'b0, level} - {1'b0, rel_step};
    att_hit  = (attack_rate == '0) || (att_sum >= {1'b0, peak_level});
    dec_hit  = (decay_rate == '0) || dec_diff[LVL_W] || (dec_diff <= {1'b0, sustain_level});
    rel_hit  = (rel_step == '0) || rel_diff[LVL_W] || (rel_diff[LVL_W-1:0] == '0);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_IDLE;
      level <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (note_on) begin
        state <= ST_ATTACK;
        busy  <= 1'b1;
      end else if (note_off && (state == ST_ATTACK || state == ST_DECAY ||
                                state == ST_SUSTAIN)) begin
        state <= ST_RELEASE;
      end else if (tick) begin
        case (state)
          ST_ATTACK: begin
            if (att_hit) begin
              level <= peak_level;
              state <= ST_DECAY;
            end else begin
              level <= att_sum[LVL_W-1:0];
            end
          end
          ST_DECAY: begin
            if (dec_hit) begin
              level <= sustain_level;
              state <= ST_SUSTAIN;
            end else begin
              level <= dec_diff[LVL_W-1:0];
            end
          end
          ST_SUSTAIN: level <= sustain_level;
          ST_RELEASE: begin
            if (rel_hit) begin
              level <= '0;
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              level <= rel_diff[LVL_W-1:0];
            end
          end
          ST_IDLE: level <= '0;
          default: begin
            state <= ST_IDLE;
            level <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/adsr_envelope_multi.sv
// ============================================================================
// Module  : adsr_envelope_multi
// Purpose : NUM_CH independent ADSR envelopes with per-channel config decode.
//           Optional macro EG_EXP_RELEASE_EN: exponential-style release.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module adsr_envelope_multi
  import eg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int LVL_W  = 18,
  parameter int CH_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    tick,
  input  logic [NUM_CH-1:0]       note_on,
  input  logic [NUM_CH-1:0]       note_off,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [2:0]              cfg_sel,
  input  logic [LVL_W-1:0]        cfg_data,
  output logic [NUM_CH*LVL_W-1:0] level_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  // Channel numbers at or above NUM_CH match no instance, so those writes vanish.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

    eg_channel #(.LVL_W(LVL_W)) u_ch (
      .clk      (clk),
      .rst_b    (rst_b),
      .tick     (tick),
      .note_on  (note_on[i]),
      .note_off (note_off[i]),
      .cfg_we   (ch_we),
      .cfg_sel  (cfg_sel),
      .cfg_data (cfg_data),
      .level    (level_out[i*LVL_W +: LVL_W]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_adsr_envelope_multi.sv
// ============================================================================
// Module  : tb_adsr_envelope_multi
// Purpose : Directed self-checking bench for adsr_envelope_multi.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_adsr_envelope_multi;

  localparam int NUM_CH = 4;
  localparam int LVL_W  = 18;
  localparam int CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst_b = 1'b0;
  logic                    tick = 1'b0;
  logic [NUM_CH-1:0]       note_on = '0;
  logic [NUM_CH-1:0]       note_off = '0;
  logic                    cfg_we = 1'b0;
  logic [CH_W-1:0]         cfg_ch = '0;
  logic [2:0]              cfg_sel = '0;
  logic [LVL_W-1:0]        cfg_data = '0;
  logic [NUM_CH*LVL_W-1:0] level_out;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;

  int checks = 0;
  int passed = 0;

  adsr_envelope_multi #(.NUM_CH(NUM_CH), .LVL_W(LVL_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst_b(rst_b), .tick(tick), .note_on(note_on), .note_off(note_off),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .level_out(level_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lv(int ch);
    return 32'(level_out[ch*LVL_W +: LVL_W]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Three idle clocks then one tick clock: ticks every 4 clk, sampled right after.
  task automatic tk();
    cyc(3);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic cfg(int ch, int sel, int data);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_sel = 3'(sel); cfg_data = LVL_W'(data);
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic non(logic [NUM_CH-1:0] m);
    note_on = m;
    cyc(1);
    note_on = '0;
  endtask

  task automatic noff(logic [NUM_CH-1:0] m);
    note_off = m;
    cyc(1);
    note_off = '0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_level", 32'(|level_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    cyc(1);
    rst_b = 1'b1;
    cyc(1);

    // Normal envelope on ch0
    cfg(0, 4, 1000); cfg(0, 0, 100); cfg(0, 1, 50); cfg(0, 2, 600); cfg(0, 3, 200);
    non(4'b0001);
    chk("on_busy", 32'(busy[0]), 1);
    chk("on_level", lv(0), 0);
    for (int k = 1; k <= 10; k++) begin tk(); chk("attack", lv(0), 32'(100 * k)); end
    for (int k = 1; k <= 8; k++) begin tk(); chk("decay", lv(0), 32'(1000 - 50 * k)); end
    tk(); chk("sustain", lv(0), 600);
    chk("sus_busy", 32'(busy[0]), 1);
    noff(4'b0001);
    tk(); chk("rel1", lv(0), 400);
    tk(); chk("rel2", lv(0), 200);
    tk(); chk("rel_end", lv(0), 0);
    chk("rel_done", 32'(done[0]), 1);
    chk("rel_busy", 32'(busy[0]), 0);
    cyc(1);
    chk("done_1clk", 32'(done[0]), 0);

    // Attack saturation
    cfg(0, 0, 300);
    non(4'b0001);
    tk(); chk("sat1", lv(0), 300);
    tk(); chk("sat2", lv(0), 600);
    tk(); chk("sat3", lv(0), 900);
    tk(); chk("sat4", lv(0), 1000);
    tk(); chk("sat_decay", lv(0), 950);

    // Retrigger from RELEASE at 400
    cfg(0, 0, 100);
    for (int k = 1; k <= 7; k++) tk();
    chk("pre_retrig", lv(0), 600);
    noff(4'b0001);
    tk(); chk("retrig_rel", lv(0), 400);
    non(4'b0001);
    for (int k = 1; k <= 6; k++) begin
      tk();
      chk("retrig_atk", lv(0), 32'(400 + 100 * k));
      chk("retrig_nodone", 32'(done[0]), 0);
    end
    tk(); chk("retrig_dec", lv(0), 950);
    note_on = 4'b0001; note_off = 4'b0001;
    cyc(1);
    note_on = '0; note_off = '0;
    tk(); chk("on_wins", lv(0), 1000);

    // Zero rates
    cfg(0, 3, 0);
    noff(4'b0001);
    tk(); chk("rel0_level", lv(0), 0);
    chk("rel0_done", 32'(done[0]), 1);
    cfg(0, 0, 0); cfg(0, 2, 1200);
    non(4'b0001);
    tk(); chk("atk0", lv(0), 1000);
    tk(); chk("sus_gt_peak", lv(0), 1200);
    tk(); chk("sus_hold", lv(0), 1200);
    cfg(0, 2, 700);
    tk(); chk("sus_follow", lv(0), 700);
    noff(4'b0001);
    tk(); chk("ch0_idle", lv(0), 0);

    // Channel isolation
    cfg(1, 4, 1000); cfg(1, 0, 200); cfg(1, 1, 10); cfg(1, 2, 500);
    cfg(3, 4, 1000); cfg(3, 0, 300);
    non(4'b1010);
    for (int k = 1; k <= 3; k++) begin
      tk();
      chk("iso_ch1", lv(1), 32'(200 * k));
      chk("iso_ch3", lv(3), 32'(300 * k));
    end
    chk("iso_busy", 32'(busy), 32'(4'b1010));
    cfg(2, 6, 5);
    cfg(1, 5, 0);
    tk();
    chk("drop_ch1", lv(1), 800);
    chk("iso_ch3_clamp", lv(3), 1000);
    chk("iso_ch0", lv(0), 0);
    chk("iso_ch2", lv(2), 0);
    tk();
    chk("ch1_peak", lv(1), 1000);
    chk("ch3_dflt_sus", lv(3), 131072);
    tk(); chk("ch1_decay", lv(1), 990);

    // Asynchronous reset off a clock edge
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_level", 32'(|level_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    rst_b = 1'b1;
    cyc(2);
    chk("arst_nodone", 32'(done), 0);
    non(4'b0010);
    tk(); chk("dflt_atk1", lv(1), 1);
    tk(); chk("dflt_atk2", lv(1), 2);
    cfg(2, 0, 0);
    non(4'b0100);
    tk(); chk("dflt_peak", lv(2), 262143);
    tk(); chk("dflt_decay", lv(2), 262142);
    noff(4'b0100);
    tk(); chk("dflt_rel", lv(2), 262141);

`ifdef EG_EXP_RELEASE_EN
    cfg(3, 4, 600); cfg(3, 0, 0); cfg(3, 2, 600); cfg(3, 3, 2);
    non(4'b1000);
    tk(); tk();
    chk("exp_start", lv(3), 600);
    noff(4'b1000);
    tk(); chk("exp1", lv(3), 450);
    tk(); chk("exp2", lv(3), 338);
    tk(); chk("exp3", lv(3), 254);
    for (int n = 0; n < 200 && !done[3]; n++) tk();
    chk("exp_done", 32'(done[3]), 1);
    chk("exp_zero", lv(3), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
